flag_register: RTL and testbench

//   Condition-code register (CCR) for the pipelined CPU; consumer end of the ALU flag outputs.

---
 rtl/flag_register.sv | 153 +++++++++++++++
 tb/tb_flag_register.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/flag_register.sv
// Condition-code register: latches ALU Z/N/C, resolves JZ/JN/JC, saves/restores the CCR on a LIFO across interrupt entry/RTI.
// Latency: flags 1 cycle after the request; o_branch_taken is combinational. No backpressure: every request is acted on in its cycle.
// FLAG_BYPASS_EN: when defined, jumps test the forwarded (same-cycle ALU plus SETC/CLRC) flags instead of the registered ones.
module flag_register #(
    parameter int SAVE_DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_alu_we,
    input  logic       i_zero_flag,
    input  logic       i_negative_flag,
    input  logic       i_carry_flag,
    input  logic       i_setc,
    input  logic       i_clrc,
    input  logic       i_branch_valid,
    input  logic [1:0] i_jmp_cond,
    input  logic       i_int_save,
    input  logic       i_int_restore,
    output logic       o_zero_flag,
    output logic       o_negative_flag,
    output logic       o_carry_flag,
    output logic       o_branch_taken,
    output logic       o_save_empty,
    output logic       o_save_full,
    output logic       o_save_err
);

    localparam int CW = $clog2(SAVE_DEPTH + 1);
    localparam int NS = 1 << CW;
    localparam logic [CW-1:0] DEPTH_C = CW'(SAVE_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        COND_NONE = 2'b00,
        COND_JZ   = 2'b01,
        COND_JN   = 2'b10,
        COND_JC   = 2'b11
    } jmp_cond_t;

    logic          z_q, n_q, c_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    slots_q [NS];

    logic          fwd_z, fwd_n, fwd_c;
    logic          taken;
    logic          stack_full, stack_empty;
    logic          push_ok, push_err, pop_ok, pop_err;
    logic          nz, nn, nc;
    logic [2:0]    top_slot;

`ifdef FLAG_BYPASS_EN
    assign fwd_z = i_alu_we ? i_zero_flag     : z_q;
    assign fwd_n = i_alu_we ? i_negative_flag : n_q;
    assign fwd_c = i_setc ? 1'b1 :
                   i_clrc ? 1'b0 :
                   (i_alu_we ? i_carry_flag : c_q);
`else
    assign fwd_z = z_q;
    assign fwd_n = n_q;
    assign fwd_c = c_q;
`endif

    always_comb begin
        taken = 1'b0;
        if (i_branch_valid) begin
            case (jmp_cond_t'(i_jmp_cond))
                COND_JZ: taken = fwd_z;
                COND_JN: taken = fwd_n;
                COND_JC: taken = fwd_c;
                default: taken = 1'b0;
            endcase
        end
    end

    assign stack_full  = (cnt_q == DEPTH_C);
    assign stack_empty = (cnt_q == '0);

    // A simultaneous save wins over restore; the restore is silently dropped.
    assign push_ok  = i_int_save & ~stack_full;
    assign push_err = i_int_save &  stack_full;
    assign pop_ok   = i_int_restore & ~i_int_save & ~stack_empty;
    assign pop_err  = i_int_restore & ~i_int_save &  stack_empty;

    assign top_slot = slots_q[cnt_q - ONE_C];

    always_comb begin
        nz = z_q;
        nn = n_q;
        nc = c_q;
        if (pop_ok) begin
            {nz, nn, nc} = top_slot;
        end else begin
            if (i_alu_we) begin
                nz = i_zero_flag;
                nn = i_negative_flag;
                nc = i_carry_flag;
            end
            if (i_setc) begin
                nc = 1'b1;
            end else if (i_clrc) begin
                nc = 1'b0;
            end
            // A taken jump consumes its flag; this beats ALU and SETC/CLRC writes.
            if (taken) begin
                case (jmp_cond_t'(i_jmp_cond))
                    COND_JZ: nz = 1'b0;
                    COND_JN: nn = 1'b0;
                    COND_JC: nc = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            z_q <= nz;
            n_q <= nn;
            c_q <= nc;
            if (push_ok) begin
                cnt_q <= cnt_q + ONE_C;
            end else if (pop_ok) begin
                cnt_q <= cnt_q - ONE_C;
            end
            if (push_err || pop_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Slots hold the pre-update CCR and are never cleared; the count alone marks validity.
    always_ff @(posedge i_clk) begin
        if (!i_reset && push_ok) begin
            slots_q[cnt_q] <= {z_q, n_q, c_q};
        end
    end

    assign o_zero_flag     = z_q;
    assign o_negative_flag = n_q;
    assign o_carry_flag    = c_q;
    assign o_branch_taken  = taken;
    assign o_save_empty    = stack_empty;
    assign o_save_full     = stack_full;
    assign o_save_err      = err_q;

endmodule

// File: tb/tb_flag_register.sv
// Directed bench for flag_register: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_flag_register;

`ifdef FLAG_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       alu_we;
    logic       zero_in, neg_in, carry_in;
    logic       setc, clrc;
    logic       branch_valid;
    logic [1:0] jmp_cond;
    logic       int_save, int_restore;
    logic       zero_out, neg_out, carry_out;
    logic       branch_taken;
    logic       save_empty, save_full, save_err;

    typedef struct {
        int         id;
        logic       taken;
        logic [2:0] znc;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_id   = 0;

    flag_register #(.SAVE_DEPTH(2)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_alu_we        (alu_we),
        .i_zero_flag     (zero_in),
        .i_negative_flag (neg_in),
        .i_carry_flag    (carry_in),
        .i_setc          (setc),
        .i_clrc          (clrc),
        .i_branch_valid  (branch_valid),
        .i_jmp_cond      (jmp_cond),
        .i_int_save      (int_save),
        .i_int_restore   (int_restore),
        .o_zero_flag     (zero_out),
        .o_negative_flag (neg_out),
        .o_carry_flag    (carry_out),
        .o_branch_taken  (branch_taken),
        .o_save_empty    (save_empty),
        .o_save_full     (save_full),
        .o_save_err      (save_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] act, req;
            e   = sb.pop_front();
            act = {branch_taken, zero_out, neg_out, carry_out, save_empty, save_full, save_err};
            req = {e.taken, e.znc, e.empty, e.full, e.err};
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL cycle%0d taken,Z,N,C,empty,full,err actual=%b required=%b", e.id, act, req);
            end
        end
    end

    // Drives one cycle of inputs; the expectation covers outputs seen during this cycle.
    task automatic cyc(input logic rst, input logic we, input logic [2:0] znc_in,
                       input logic sc, input logic cc, input logic bv, input logic [1:0] cond,
                       input logic sv, input logic rs, input logic chk,
                       input logic e_taken, input logic [2:0] e_znc,
                       input logic e_empty, input logic e_full, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        alu_we       = we;
        {zero_in, neg_in, carry_in} = znc_in;
        setc         = sc;
        clrc         = cc;
        branch_valid = bv;
        jmp_cond     = cond;
        int_save     = sv;
        int_restore  = rs;
        cyc_id++;
        if (chk) begin
            e.id    = cyc_id;
            e.taken = e_taken;
            e.znc   = e_znc;
            e.empty = e_empty;
            e.full  = e_full;
            e.err   = e_err;
            sb.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1; alu_we = 0; zero_in = 0; neg_in = 0; carry_in = 0;
        setc = 0; clrc = 0; branch_valid = 0; jmp_cond = 2'b00;
        int_save = 0; int_restore = 0;

        //  rst we znc    sc cc bv cond  sv rs chk tk  eZNC   emp ful err
        cyc(1, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        cyc(0, 1, 3'b101, 0, 0, 0, 2'b00, 0, 0, 1, 0, 3'b000, 1, 0, 0); // reset state
        cyc(0, 0, 3'b000, 0, 0, 1, 2'b01, 0, 0, 1, 1, 3'b101, 1, 0, 0); // JZ taken
        cyc(0, 0, 3'b000, 0, 1, 0, 2'b00, 0, 0, 1, 0, 3'b001, 1, 0, 0); // Z cleared; CLRC
        cyc(0, 1, 3'b000, 1, 1, 0, 2'b00, 0, 0, 1, 0, 3'b000, 1, 0, 0); // SETC beats CLRC and ALU
        cyc(0, 1, 3'b101, 0, 0, 0, 2'b00, 0, 0, 1, 0, 3'b001, 1, 0, 0);
        cyc(0, 1, 3'b010, 0, 0, 0, 2'b00, 1, 0, 1, 0, 3'b101, 1, 0, 0); // push 101, ALU still loads
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 1, 0, 1, 0, 3'b010, 0, 0, 0); // push 010
        cyc(0, 1, 3'b111, 0, 0, 0, 2'b00, 1, 0, 1, 0, 3'b010, 0, 1, 0); // push when full
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 1, 1, 0, 3'b111, 0, 1, 1); // pop -> 010
        cyc(0, 1, 3'b111, 0, 0, 0, 2'b00, 0, 1, 1, 0, 3'b010, 0, 0, 1); // pop -> 101, ALU ignored
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1, 0, 3'b101, 1, 0, 1);
        cyc(0, 1, 3'b010, 0, 0, 0, 2'b00, 0, 1, 1, 0, 3'b101, 1, 0, 1); // pop when empty, ALU loads
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 1, 0, 1, 0, 3'b010, 1, 0, 1); // push before reset
        cyc(1, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1, 0, 3'b010, 0, 0, 1); // reset mid-sequence
        cyc(0, 1, 3'b001, 0, 0, 0, 2'b00, 1, 1, 1, 0, 3'b000, 1, 0, 0); // save+restore: save only
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 1, 1, 0, 3'b001, 0, 0, 0); // pop -> 000
        cyc(0, 1, 3'b110, 0, 0, 0, 2'b00, 0, 0, 1, 0, 3'b000, 1, 0, 0);
        cyc(0, 0, 3'b000, 0, 0, 1, 2'b00, 0, 0, 1, 0, 3'b110, 1, 0, 0); // cond 00 not taken
        cyc(0, 0, 3'b000, 0, 0, 1, 2'b10, 0, 0, 1, 1, 3'b110, 1, 0, 0); // JN taken
        cyc(0, 0, 3'b000, 0, 0, 1, 2'b11, 0, 0, 1, 0, 3'b100, 1, 0, 0); // JC with C=0
        cyc(0, 0, 3'b000, 1, 0, 0, 2'b00, 0, 0, 1, 0, 3'b100, 1, 0, 0);
        cyc(0, 0, 3'b000, 1, 0, 1, 2'b11, 0, 0, 1, 1, 3'b101, 1, 0, 0); // JC clear beats SETC
        cyc(0, 1, 3'b001, 0, 0, 0, 2'b00, 0, 0, 1, 0, 3'b100, 1, 0, 0);
        cyc(0, 1, 3'b100, 0, 0, 1, 2'b01, 0, 0, 1, BYP, 3'b001, 1, 0, 0); // JZ behind ALU write
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 1, 1, 0, (BYP ? 3'b000 : 3'b100), 1, 0, 0);
        cyc(0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1, 0, (BYP ? 3'b000 : 3'b100), 1, 0, 1);

        @(posedge clk);
        #1;
        alu_we = 0; branch_valid = 0; int_save = 0; int_restore = 0; setc = 0; clrc = 0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
